// File: rtl/fir_xifu_pkg.sv
// Shared types for the XIF commit tracker: per-entry lifecycle state and entry record.
// Ids are stored zero-extended to XIF_ID_WIDTH_MAX so the record type is width-independent.
package fir_xifu_pkg;

  localparam int unsigned XIF_ID_WIDTH_MAX = 16;

  typedef enum logic [1:0] {
    ENTRY_FREE      = 2'd0,
    ENTRY_ISSUED    = 2'd1,
    ENTRY_COMMITTED = 2'd2,
    ENTRY_KILLED    = 2'd3
  } entry_state_e;

  typedef struct packed {
    logic [XIF_ID_WIDTH_MAX-1:0] id;
    entry_state_e                state;
  } entry_t;

endpackage

// File: rtl/fir_xifu_commit_tracker_if.sv
// XIF-side handshake bundle for the commit tracker: issue, commit and writeback/retire.
// The master modport is the core/offload side; the slave modport is the tracker side.
interface fir_xifu_commit_tracker_if #(
  parameter int ID_WIDTH = 4,
  parameter int CNT_WIDTH = 3
);
  logic                 issue_valid;
  logic [ID_WIDTH-1:0]  issue_id;
  logic                 issue_ready;
  logic                 commit_valid;
  logic [ID_WIDTH-1:0]  commit_id;
  logic                 commit_kill;
  logic                 head_valid;
  logic [ID_WIDTH-1:0]  head_id;
  logic                 retire;
  logic [CNT_WIDTH-1:0] count;
  logic                 err;

  modport master (
    output issue_valid, issue_id, commit_valid, commit_id, commit_kill, retire,
    input  issue_ready, head_valid, head_id, count, err
  );

  modport slave (
    input  issue_valid, issue_id, commit_valid, commit_id, commit_kill, retire,
    output issue_ready, head_valid, head_id, count, err
  );
endinterface

// File: rtl/fir_xifu_commit_cam.sv
// Oldest-first id match over the circular entry buffer: finds the first ISSUED entry,
// starting at the read pointer, whose id equals i_id.
module fir_xifu_commit_cam
  import fir_xifu_pkg::*;
#(
  parameter int NB = 4,
  parameter int PW = 2
) (
  input  entry_t                      i_entries [NB],
  input  logic [PW-1:0]               i_rd_ptr,
  input  logic [XIF_ID_WIDTH_MAX-1:0] i_id,
  output logic                        o_hit,
  output logic [PW-1:0]               o_idx
);

  logic [PW-1:0] w_idx;

  // Scan youngest-to-oldest so the oldest match is the one left standing.
  always_comb begin
    o_hit = 1'b0;
    o_idx = i_rd_ptr;
    w_idx = i_rd_ptr;
    for (int k = NB - 1; k >= 0; k--) begin
      w_idx = i_rd_ptr + PW'(k);
      if (i_entries[w_idx].state == ENTRY_ISSUED && i_entries[w_idx].id == i_id) begin
        o_hit = 1'b1;
        o_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/fir_xifu_commit_tracker.sv
// In-order tracker for offloaded XIF instructions: issue/commit/kill bookkeeping and head writeback.
// Optional perf counters (successful commits, kills) when FIR_XIFU_TRACKER_PERF_EN is defined.
module fir_xifu_commit_tracker
  import fir_xifu_pkg::*;
#(
  parameter int NB_OUTSTANDING = 4,
  parameter int ID_WIDTH       = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  issue_valid_i,
  input  logic [ID_WIDTH-1:0]                   issue_id_i,
  output logic                                  issue_ready_o,
  input  logic                                  commit_valid_i,
  input  logic [ID_WIDTH-1:0]                   commit_id_i,
  input  logic                                  commit_kill_i,
  output logic                                  head_valid_o,
  output logic [ID_WIDTH-1:0]                   head_id_o,
  input  logic                                  retire_i,
  output logic [$clog2(NB_OUTSTANDING+1)-1:0]   count_o,
  output logic                                  err_o
`ifdef FIR_XIFU_TRACKER_PERF_EN
  ,
  output logic [31:0]                           n_commit_o,
  output logic [31:0]                           n_kill_o
`endif
);

  localparam int PW = $clog2(NB_OUTSTANDING);
  localparam int CW = $clog2(NB_OUTSTANDING + 1);

  entry_t        r_entries [NB_OUTSTANDING];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_err;

  logic [XIF_ID_WIDTH_MAX-1:0] w_issue_id;
  logic [XIF_ID_WIDTH_MAX-1:0] w_commit_id;
  logic          w_empty, w_full, w_push, w_pop, w_drop, w_deq;
  logic          w_cam_hit, w_dup_hit, w_commit_hit, w_err_evt;
  logic [PW-1:0] w_cam_idx, w_dup_idx;

  assign w_issue_id  = XIF_ID_WIDTH_MAX'(issue_id_i);
  assign w_commit_id = XIF_ID_WIDTH_MAX'(commit_id_i);

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(NB_OUTSTANDING));

  assign issue_ready_o = !w_full;
  assign head_valid_o  = !w_empty && (r_entries[r_rd_ptr].state == ENTRY_COMMITTED);
  assign head_id_o     = w_empty ? '0 : r_entries[r_rd_ptr].id[ID_WIDTH-1:0];
  assign count_o       = r_count;
  assign err_o         = r_err;

  assign w_push = issue_valid_i && !w_full;
  assign w_pop  = retire_i && head_valid_o;
  assign w_drop = !w_empty && (r_entries[r_rd_ptr].state == ENTRY_KILLED);
  assign w_deq  = w_pop || w_drop;

  fir_xifu_commit_cam #(.NB(NB_OUTSTANDING), .PW(PW)) u_commit_cam (
    .i_entries (r_entries),
    .i_rd_ptr  (r_rd_ptr),
    .i_id      (w_commit_id),
    .o_hit     (w_cam_hit),
    .o_idx     (w_cam_idx)
  );

  // Second lookup flags an issue whose id is still awaiting its commit.
  fir_xifu_commit_cam #(.NB(NB_OUTSTANDING), .PW(PW)) u_dup_cam (
    .i_entries (r_entries),
    .i_rd_ptr  (r_rd_ptr),
    .i_id      (w_issue_id),
    .o_hit     (w_dup_hit),
    .o_idx     (w_dup_idx)
  );

  assign w_commit_hit = commit_valid_i && w_cam_hit;
  assign w_err_evt    = (commit_valid_i && !w_cam_hit) ||
                        (issue_valid_i && (w_full || w_dup_hit));

  // A matched entry is ISSUED, so it never aliases the dequeued head or the free write slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NB_OUTSTANDING; i++) begin
        r_entries[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_entries[r_wr_ptr] <= '{id: w_issue_id, state: ENTRY_ISSUED};
        r_wr_ptr            <= r_wr_ptr + PW'(1);
      end
      if (w_commit_hit) begin
        r_entries[w_cam_idx].state <= commit_kill_i ? ENTRY_KILLED : ENTRY_COMMITTED;
      end
      if (w_deq) begin
        r_entries[r_rd_ptr].state <= ENTRY_FREE;
        r_rd_ptr                  <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_deq) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_deq) begin
        r_count <= r_count - CW'(1);
      end
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef FIR_XIFU_TRACKER_PERF_EN
  logic [31:0] r_n_commit;
  logic [31:0] r_n_kill;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_n_commit <= '0;
      r_n_kill   <= '0;
    end else if (w_commit_hit) begin
      if (commit_kill_i) r_n_kill <= r_n_kill + 32'd1;
      else               r_n_commit <= r_n_commit + 32'd1;
    end
  end

  assign n_commit_o = r_n_commit;
  assign n_kill_o   = r_n_kill;
`endif

endmodule

// File: tb/tb_fir_xifu_commit_tracker.sv
// Directed, table-driven bench for fir_xifu_commit_tracker (N=4, 4-bit ids), plus
// hand sequences for back-to-back kill drops and, with FIR_XIFU_TRACKER_PERF_EN, the perf counters.
module tb_fir_xifu_commit_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_xifu_commit_tracker_if #(.ID_WIDTH(4), .CNT_WIDTH(3)) xif ();

`ifdef FIR_XIFU_TRACKER_PERF_EN
  logic [31:0] n_commit;
  logic [31:0] n_kill;
`endif

  fir_xifu_commit_tracker #(.NB_OUTSTANDING(4), .ID_WIDTH(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .issue_valid_i  (xif.issue_valid),
    .issue_id_i     (xif.issue_id),
    .issue_ready_o  (xif.issue_ready),
    .commit_valid_i (xif.commit_valid),
    .commit_id_i    (xif.commit_id),
    .commit_kill_i  (xif.commit_kill),
    .head_valid_o   (xif.head_valid),
    .head_id_o      (xif.head_id),
    .retire_i       (xif.retire),
    .count_o        (xif.count),
    .err_o          (xif.err)
`ifdef FIR_XIFU_TRACKER_PERF_EN
    ,
    .n_commit_o     (n_commit),
    .n_kill_o       (n_kill)
`endif
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [3:0] iid;
    logic       cv;
    logic [3:0] cid;
    logic       ck;
    logic       ret;
    logic [2:0] e_cnt;
    logic       e_rdy;
    logic       e_hv;
    logic [3:0] e_hid;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_bad   = 0;

  function automatic vec_t mk(input logic r, input logic iv, input int iid, input logic cv,
                              input int cid, input logic ck, input logic ret, input int cnt,
                              input logic rdy, input logic hv, input int hid, input logic err);
    vec_t v;
    v.rst = r;  v.iv = iv;  v.iid = 4'(iid); v.cv = cv; v.cid = 4'(cid); v.ck = ck; v.ret = ret;
    v.e_cnt = 3'(cnt); v.e_rdy = rdy; v.e_hv = hv; v.e_hid = 4'(hid); v.e_err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [3:0] iid, input logic cv,
                       input logic [3:0] cid, input logic ck, input logic ret);
    rst              = r;
    xif.issue_valid  = iv;
    xif.issue_id     = iid;
    xif.commit_valid = cv;
    xif.commit_id    = cid;
    xif.commit_kill  = ck;
    xif.retire       = ret;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input vec_t v);
    chk("count",      idx, int'(xif.count),       int'(v.e_cnt));
    chk("issue_ready", idx, int'(xif.issue_ready), int'(v.e_rdy));
    chk("head_valid", idx, int'(xif.head_valid),  int'(v.e_hv));
    chk("head_id",    idx, int'(xif.head_id),     int'(v.e_hid));
    chk("err",        idx, int'(xif.err),         int'(v.e_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    xif.issue_valid = 1'b0; xif.issue_id = '0; xif.commit_valid = 1'b0;
    xif.commit_id = '0; xif.commit_kill = 1'b0; xif.retire = 1'b0;

    //           rst iv iid cv cid ck ret | cnt rdy hv hid err
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
    // in-order commit
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0,  1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0,  2, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0,  3, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0,  3, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2, 0, 0,  3, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0,  3, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  2, 1, 1, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 1, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0));
    // out-of-order commit
    vecs.push_back(mk(0, 1, 5, 0, 0, 0, 0,  1, 1, 0, 5, 0));
    vecs.push_back(mk(0, 1, 6, 0, 0, 0, 0,  2, 1, 0, 5, 0));
    vecs.push_back(mk(0, 0, 0, 1, 6, 0, 0,  2, 1, 0, 5, 0));
    vecs.push_back(mk(0, 0, 0, 1, 5, 0, 0,  2, 1, 1, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 1, 1, 6, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0));
    // killed head dropped without retire
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0,  1, 1, 0, 2, 0));
    vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0,  2, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2, 1, 0,  2, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0,  1, 1, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0));
    // full, no same-cycle bypass, wrap
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0,  1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0,  2, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0,  3, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 4, 0, 0, 0, 0,  4, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0,  4, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 5, 0, 0, 0, 1,  3, 1, 0, 2, 1));
    vecs.push_back(mk(0, 1, 5, 0, 0, 0, 0,  4, 0, 0, 2, 1));
    vecs.push_back(mk(0, 0, 0, 1, 2, 0, 0,  4, 0, 1, 2, 1));
    vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0,  4, 0, 1, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  3, 1, 1, 3, 1));
    vecs.push_back(mk(0, 1, 6, 1, 4, 0, 1,  3, 1, 1, 4, 1));
    vecs.push_back(mk(0, 0, 0, 1, 5, 0, 1,  2, 1, 1, 5, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 6, 1));
    vecs.push_back(mk(0, 0, 0, 1, 6, 0, 0,  1, 1, 1, 6, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 1));
    // errors: unmatched commit, sticky, duplicate issue, reset clears
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 9, 0, 0,  0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 7, 0, 0, 0, 0,  1, 1, 0, 7, 0));
    vecs.push_back(mk(0, 1, 7, 0, 0, 0, 0,  2, 1, 0, 7, 1));
    vecs.push_back(mk(1, 1, 8, 1, 7, 0, 1,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].iid, vecs[i].cv, vecs[i].cid, vecs[i].ck, vecs[i].ret);
      check_all(i, vecs[i]);
    end

    // two killed entries drain one per cycle, never raising head_valid
    drive(1, 0, 4'd0, 0, 4'd0, 0, 0);
    drive(0, 1, 4'd1, 0, 4'd0, 0, 0);
    drive(0, 1, 4'd2, 0, 4'd0, 0, 0);
    drive(0, 0, 4'd0, 1, 4'd1, 1, 0);
    chk("kill_cnt_a", 100, int'(xif.count), 2);
    chk("kill_hv_a",  100, int'(xif.head_valid), 0);
    drive(0, 0, 4'd0, 1, 4'd2, 1, 0);
    chk("kill_cnt_b", 101, int'(xif.count), 1);
    chk("kill_hv_b",  101, int'(xif.head_valid), 0);
    chk("kill_hid_b", 101, int'(xif.head_id), 2);
    drive(0, 0, 4'd0, 0, 4'd0, 0, 0);
    chk("kill_cnt_c", 102, int'(xif.count), 0);
    chk("kill_err_c", 102, int'(xif.err), 0);

`ifdef FIR_XIFU_TRACKER_PERF_EN
    drive(1, 0, 4'd0, 0, 4'd0, 0, 0);
    chk("perf_rst_commit", 200, int'(n_commit), 0);
    chk("perf_rst_kill",   200, int'(n_kill), 0);
    drive(0, 1, 4'd1, 0, 4'd0, 0, 0);
    drive(0, 1, 4'd2, 0, 4'd0, 0, 0);
    drive(0, 1, 4'd3, 0, 4'd0, 0, 0);
    drive(0, 1, 4'd4, 0, 4'd0, 0, 0);
    drive(0, 0, 4'd0, 1, 4'd1, 0, 0);
    drive(0, 0, 4'd0, 1, 4'd2, 1, 0);
    drive(0, 0, 4'd0, 1, 4'd3, 0, 0);
    drive(0, 0, 4'd0, 1, 4'd4, 1, 0);
    drive(0, 0, 4'd0, 0, 4'd0, 0, 1);
    drive(0, 1, 4'd5, 0, 4'd0, 0, 0);
    drive(0, 0, 4'd0, 1, 4'd5, 0, 0);
    chk("perf_commit", 201, int'(n_commit), 3);
    chk("perf_kill",   201, int'(n_kill), 2);
    chk("perf_err",    201, int'(xif.err), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
